ptp_perout_cfg_ctrl: RTL and testbench
======================================

# ptp_perout_cfg_ctrl

Reconfiguration sequencer for the `ptp_perout` periodic-output generator driven by `ptp_clock`. It accepts a start/period/width request over a valid/ready handshake and validates the timestamps. It then disables the output, waits for the generator to drop lock, loads the three registers with single-cycle valid strobes, re-enables, and supervises re-lock with a timeout. The block sits between the host/CSR side and `ptp_perout`, and is the only driver of that generator's `enable` and `input_*` configuration ports.

## Interface

- `TS_WIDTH`, 96: timestamp width, fixed 96-bit format: s[95:48], ns[45:16], fns[15:0].
- `TIMEOUT_CYCLES`, 65535: cycles allowed in each wait state before fault; must be ≥1.
- `clk` in 1: system clock, same domain as `ptp_clock` / `ptp_perout`.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cfg_start` in 96: requested first-edge time.
- `cfg_period` in 96: requested period.
- `cfg_width` in 96: requested pulse width.
- `cfg_valid` in 1: request valid.
- `cfg_ready` out 1: high only in IDLE.
- `perout_enable` out 1: to `ptp_perout.enable`.
- `perout_start`, `perout_period`, `perout_width` out 96 each: latched request values.
- `perout_start_valid`, `perout_period_valid`, `perout_width_valid` out 1 each: one-cycle load strobes.
- `perout_locked` in 1: from `ptp_perout.locked`.
- `perout_error` in 1: from `ptp_perout.error`.
- `ts_step` in 1: from `ptp_clock.output_ts_step`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on successful re-lock.
- `fault` out 1: one-cycle pulse on timeout, `perout_error`, or rejected request.
- `fault_code` out 2: 0 none, 1 bad ns field, 2 timeout, 3 perout_error; holds until the next accepted request.

## Operation

- States: IDLE, DISABLE, WAIT_UNLOCK, LOAD_START, LOAD_PERIOD, LOAD_WIDTH, ENABLE, WAIT_LOCK.
- Acceptance is `cfg_valid && cfg_ready`. Latch all three values and clear `fault_code`.
- Validation is done in the acceptance cycle. If the ns field of any input is ≥ 1_000_000_000:
  - reject: stay in IDLE, pulse `fault`, set `fault_code=1`;
  - outputs and `perout_enable` are untouched.
- Otherwise go to DISABLE.
- DISABLE: drive `perout_enable=0`, then go to WAIT_UNLOCK.
- WAIT_UNLOCK: wait for `perout_locked==0`, then go to LOAD_START.
- LOAD_START → LOAD_PERIOD → LOAD_WIDTH: the matching `*_valid` is high for exactly that one cycle.
- ENABLE: set `perout_enable=1`, then go to WAIT_LOCK.
- WAIT_LOCK:
  - `perout_locked==1` → pulse `done`, go to IDLE with `perout_enable` held 1.
  - `perout_error==1` → pulse `fault`, `fault_code=3`, `perout_enable=0`, go to IDLE.
  - If `perout_locked` and `perout_error` are high in the same cycle, error wins.
- Timeout counter:
  - Cleared on entry to WAIT_UNLOCK and to WAIT_LOCK.
  - Increments each cycle spent in either state.
  - Reaching `TIMEOUT_CYCLES` → `fault`, `fault_code=2`, `perout_enable=0`, go to IDLE.
  - A `ts_step` in WAIT_LOCK clears the counter, because a clock step legitimately delays lock.
- `cfg_valid` while busy is ignored, since `cfg_ready` is low. Requests are never queued.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The compare is equality and the counter never wraps.

## Timing

- Reset values (all outputs):
  - state IDLE, `cfg_ready=1`, `perout_enable=0`;
  - all strobes 0, `busy=0`, `done=0`, `fault=0`, `fault_code=0`;
  - `perout_start`, `perout_period`, `perout_width` = 0.
- All outputs are registered. `cfg_ready` and `busy` decode from the state register.
- Cycle timing, with accept on edge E:
  - `perout_enable` falls at E+1.
  - If `perout_locked` is already 0: `perout_start_valid` at E+2, `perout_period_valid` at E+3, `perout_width_valid` at E+4.
  - `perout_enable` rises at E+5.
- `done` is asserted the cycle after `perout_locked` is sampled high in WAIT_LOCK.
- `perout_start`, `perout_period` and `perout_width` are stable from E+1 until the next acceptance.
- `rst_n` low mid-sequence forces the reset values immediately. No partial load is completed after release.

## Structure

- Shared package `ptp_pkg`:
  - timestamp field slice constants (`TS_S_MSB/LSB`, `TS_NS_MSB/LSB`, `TS_FNS_MSB/LSB`);
  - `NS_PER_S=1_000_000_000`;
  - state enum;
  - `fault_code` constants.
- One natural sub-module, `ptp_ts_check`: combinational ns-range validator, instantiated 3×.
- The FSM and timeout counter stay in the top module.

## Test plan

- Nominal load: `perout_locked=0`, request start={s=1,ns=0}, period={ns=100_000_000}, width={ns=25_000_000}; `perout_locked` raised 10 cycles after enable → expected:
  - strobes at E+2/E+3/E+4, enable rises at E+5;
  - `done` 1 cycle after lock, `perout_enable` stays 1.
- Running reconfigure: `perout_locked=1` at accept, dropped 3 cycles later → expected:
  - enable falls at E+1 and the FSM holds WAIT_UNLOCK;
  - first strobe one cycle after `perout_locked` is sampled 0.
- Bad request: period ns=1_000_000_000 → `fault` pulse, `fault_code=1`, no strobes, `busy` stays 0.
- Timeout: `TIMEOUT_CYCLES=16`, lock never raised → expected:
  - `fault` 16 cycles into WAIT_LOCK, `fault_code=2`, `perout_enable=0`;
  - a repeat run with a `ts_step` at cycle 10 extends the fault to cycle 26.
- Error/lock collision: `perout_locked` and `perout_error` high in the same WAIT_LOCK cycle → `fault_code=3`, no `done`.
- Reset mid-load: drop `rst_n` during LOAD_PERIOD → all outputs are at reset values at once; after release `cfg_ready=1` and no strobes fire.

Source files
------------

// File: rtl/ptp_pkg.sv
// Shared PTP definitions: timestamp field layout, ns range limit,
// reconfiguration sequencer states and fault codes.
package ptp_pkg;

    localparam int unsigned TS_S_MSB   = 95;
    localparam int unsigned TS_S_LSB   = 48;
    localparam int unsigned TS_NS_MSB  = 45;
    localparam int unsigned TS_NS_LSB  = 16;
    localparam int unsigned TS_FNS_MSB = 15;
    localparam int unsigned TS_FNS_LSB = 0;

    localparam int unsigned NS_PER_S = 1_000_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISABLE,
        ST_WAIT_UNLOCK,
        ST_LOAD_START,
        ST_LOAD_PERIOD,
        ST_LOAD_WIDTH,
        ST_ENABLE,
        ST_WAIT_LOCK
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_BAD_NS     = 2'd1,
        FC_TIMEOUT    = 2'd2,
        FC_PEROUT_ERR = 2'd3
    } fault_code_e;

endpackage

// File: rtl/ptp_ts_check.sv
// Combinational range check of a timestamp ns field (must be below one second).
module ptp_ts_check
    import ptp_pkg::*;
(
    input  logic [TS_NS_MSB-TS_NS_LSB:0] ns_i,
    output logic                         bad_o
);

    assign bad_o = (32'(ns_i) >= NS_PER_S);

endmodule

// File: rtl/ptp_perout_cfg_ctrl.sv
// Reconfiguration sequencer for ptp_perout: validates a start/period/width
// request, disables the output, loads the registers, re-enables and supervises lock.
module ptp_perout_cfg_ctrl
    import ptp_pkg::*;
#(
    parameter int unsigned TS_WIDTH       = 96,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TS_WIDTH-1:0] cfg_start,
    input  logic [TS_WIDTH-1:0] cfg_period,
    input  logic [TS_WIDTH-1:0] cfg_width,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                perout_enable,
    output logic [TS_WIDTH-1:0] perout_start,
    output logic [TS_WIDTH-1:0] perout_period,
    output logic [TS_WIDTH-1:0] perout_width,
    output logic                perout_start_valid,
    output logic                perout_period_valid,
    output logic                perout_width_valid,
    input  logic                perout_locked,
    input  logic                perout_error,
    input  logic                ts_step,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                enable_q, enable_d;
    logic [TS_WIDTH-1:0] start_q, start_d, period_q, period_d, width_q, width_d;
    logic                sv_q, sv_d, pv_q, pv_d, wv_q, wv_d;
    logic                done_q, done_d, fault_q, fault_d;
    fault_code_e         fcode_q, fcode_d;
    logic                bad_start, bad_period, bad_width;

    ptp_ts_check u_chk_start  (.ns_i(cfg_start[TS_NS_MSB:TS_NS_LSB]),  .bad_o(bad_start));
    ptp_ts_check u_chk_period (.ns_i(cfg_period[TS_NS_MSB:TS_NS_LSB]), .bad_o(bad_period));
    ptp_ts_check u_chk_width  (.ns_i(cfg_width[TS_NS_MSB:TS_NS_LSB]),  .bad_o(bad_width));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = enable_q;
        start_d  = start_q;
        period_d = period_q;
        width_d  = width_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        fcode_d  = fcode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (bad_start || bad_period || bad_width) begin
                        fault_d = 1'b1;
                        fcode_d = FC_BAD_NS;
                    end else begin
                        start_d  = cfg_start;
                        period_d = cfg_period;
                        width_d  = cfg_width;
                        fcode_d  = FC_NONE;
                        state_d  = ST_DISABLE;
                    end
                end
            end
            ST_DISABLE: begin
                enable_d = 1'b0;
                cnt_d    = '0;
                state_d  = ST_WAIT_UNLOCK;
            end
            ST_WAIT_UNLOCK: begin
                if (!perout_locked) begin
                    state_d = ST_LOAD_START;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d  = 1'b1;
                    fcode_d  = FC_TIMEOUT;
                    enable_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD_START:  state_d = ST_LOAD_PERIOD;
            ST_LOAD_PERIOD: state_d = ST_LOAD_WIDTH;
            // Enable is registered on entry to ENABLE so it rises with that state.
            ST_LOAD_WIDTH: begin
                enable_d = 1'b1;
                state_d  = ST_ENABLE;
            end
            ST_ENABLE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (perout_error) begin
                    fault_d  = 1'b1;
                    fcode_d  = FC_PEROUT_ERR;
                    enable_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (perout_locked) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (ts_step) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d  = 1'b1;
                    fcode_d  = FC_TIMEOUT;
                    enable_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sv_d = (state_d == ST_LOAD_START);
        pv_d = (state_d == ST_LOAD_PERIOD);
        wv_d = (state_d == ST_LOAD_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            start_q  <= '0;
            period_q <= '0;
            width_q  <= '0;
            sv_q     <= 1'b0;
            pv_q     <= 1'b0;
            wv_q     <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            fcode_q  <= FC_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            start_q  <= start_d;
            period_q <= period_d;
            width_q  <= width_d;
            sv_q     <= sv_d;
            pv_q     <= pv_d;
            wv_q     <= wv_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
        end
    end

    assign cfg_ready           = (state_q == ST_IDLE);
    assign busy                = (state_q != ST_IDLE);
    assign perout_enable       = enable_q;
    assign perout_start        = start_q;
    assign perout_period       = period_q;
    assign perout_width        = width_q;
    assign perout_start_valid  = sv_q;
    assign perout_period_valid = pv_q;
    assign perout_width_valid  = wv_q;
    assign done                = done_q;
    assign fault               = fault_q;
    assign fault_code          = fcode_q;

endmodule

// File: tb/tb_ptp_perout_cfg_ctrl.sv
// Randomized bench for ptp_perout_cfg_ctrl against an event-time reference model.
module tb_ptp_perout_cfg_ctrl;

    localparam int T    = 16;
    localparam int MAXK = 160;
    localparam logic [9:0] IDLE_RST = 10'b1000000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [95:0]  cfg_start, cfg_period, cfg_width;
    logic         cfg_valid, cfg_ready, perout_enable;
    logic [95:0]  perout_start, perout_period, perout_width;
    logic         perout_start_valid, perout_period_valid, perout_width_valid;
    logic         perout_locked, perout_error, ts_step;
    logic         busy, done, fault;
    logic [1:0]   fault_code;

    int checks = 0;
    int errors = 0;

    // scenario: locked is high before sc_drop and from sc_rise on; error/ts_step are single-cycle pulses
    int sc_drop, sc_rise, sc_err, sc_ts;
    // model state
    bit           m_bad, m_en0, m_enable;
    int           m_u, m_end, m_last;
    logic [1:0]   m_code;
    logic [287:0] m_data;
    logic [9:0]   obs_ctl  [0:MAXK];
    logic [287:0] obs_data [0:MAXK];

    always #5 clk = ~clk;

    ptp_perout_cfg_ctrl #(.TS_WIDTH(96), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_period(cfg_period), .cfg_width(cfg_width),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .perout_enable(perout_enable),
        .perout_start(perout_start), .perout_period(perout_period), .perout_width(perout_width),
        .perout_start_valid(perout_start_valid), .perout_period_valid(perout_period_valid),
        .perout_width_valid(perout_width_valid),
        .perout_locked(perout_locked), .perout_error(perout_error), .ts_step(ts_step),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
    );

    function automatic logic [95:0] mk_ts(input logic [47:0] s, input logic [29:0] ns, input logic [15:0] fns);
        return {s, 2'b00, ns, fns};
    endfunction

    function automatic bit locked_f(input int k);
        return (k < sc_drop) || (sc_rise >= 0 && k >= sc_rise);
    endfunction
    function automatic bit err_f(input int k);
        return k == sc_err;
    endfunction
    function automatic bit ts_f(input int k);
        return k == sc_ts;
    endfunction

    function automatic logic [9:0] ctl();
        return {cfg_ready, busy, perout_enable, perout_start_valid, perout_period_valid,
                perout_width_valid, done, fault, fault_code};
    endfunction

    // Event times, k counted in edges after the acceptance edge.
    function automatic void plan(input logic [95:0] s, p, w, input bit bad);
        int wl, dl;
        m_en0 = m_enable; m_bad = bad; m_u = -1; m_end = -1;
        if (bad) begin
            m_end = 0; m_code = 2'd1;
        end else begin
            m_data = {s, p, w};
            for (int k = 2; k <= 1 + T; k++) if (m_u < 0 && !locked_f(k)) m_u = k;
            if (m_u < 0) begin
                m_end = 1 + T; m_code = 2'd2;
            end else begin
                wl = m_u + 4; dl = wl + T;
                for (int k = wl + 1; k < MAXK - 4 && m_end < 0; k++) begin
                    if (err_f(k)) begin m_end = k; m_code = 2'd3; end
                    else if (locked_f(k)) begin m_end = k; m_code = 2'd0; end
                    else if (ts_f(k)) dl = k + T;
                    else if (k == dl) begin m_end = k; m_code = 2'd2; end
                end
            end
            m_enable = (m_code == 2'd0);
        end
        m_last = m_end + 3;
    endfunction

    function automatic logic [9:0] exp_ctl(input int k);
        logic b, en, d, f;
        logic [1:0] fc;
        if (m_bad) return {1'b1, 1'b0, m_en0, 3'b000, 1'b0, k == 0, 2'd1};
        b  = k < m_end;
        en = (k == 0) ? m_en0 : (m_u >= 0 && k >= m_u + 3 && (k < m_end || m_code == 2'd0));
        d  = (m_code == 2'd0) && k == m_end;
        f  = (m_code != 2'd0) && k == m_end;
        fc = (k < m_end) ? 2'd0 : m_code;
        return {!b, b, en, m_u >= 0 && k == m_u, m_u >= 0 && k == m_u + 1, m_u >= 0 && k == m_u + 2, d, f, fc};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one request (optionally with ignored requests while busy) and records outputs.
    task automatic run_request(input logic [95:0] s, p, w, input bit noise);
        cfg_start = s; cfg_period = p; cfg_width = w; cfg_valid = 1'b1;
        perout_locked = locked_f(0); perout_error = err_f(0); ts_step = ts_f(0);
        for (int k = 0; k <= m_last; k++) begin
            step();
            obs_ctl[k]  = ctl();
            obs_data[k] = {perout_start, perout_period, perout_width};
            cfg_valid = noise && (k + 1 <= m_end);
            if (noise) begin
                cfg_start  = {$urandom, $urandom, $urandom};
                cfg_period = {$urandom, $urandom, $urandom};
                cfg_width  = {$urandom, $urandom, $urandom};
            end
            perout_locked = locked_f(k + 1); perout_error = err_f(k + 1); ts_step = ts_f(k + 1);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; perout_locked = 1'b0; perout_error = 1'b0; ts_step = 1'b0;
        cfg_start = '0; cfg_period = '0; cfg_width = '0;
        m_enable = 1'b0; m_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctl() !== IDLE_RST) begin errors++; $display("FAIL reset_ctl got %b expected %b", ctl(), IDLE_RST); end
        checks++;
        if ({perout_start, perout_period, perout_width} !== 288'd0) begin
            errors++; $display("FAIL reset_data got %h expected 0", {perout_start, perout_period, perout_width});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (ctl() !== IDLE_RST) begin errors++; $display("FAIL reset_release got %b expected %b", ctl(), IDLE_RST); end
    endtask

    task automatic test_nominal();
        logic [95:0] s, p, w;
        s = mk_ts(48'd1, 30'd0, 16'd0); p = mk_ts(48'd0, 30'd100_000_000, 16'd0); w = mk_ts(48'd0, 30'd25_000_000, 16'd0);
        sc_drop = 0; sc_rise = 15; sc_err = -1; sc_ts = -1;
        plan(s, p, w, 1'b0);
        run_request(s, p, w, 1'b0);
        for (int k = 0; k <= m_last; k++) begin
            checks++;
            if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL nominal k=%0d ctl got %b expected %b", k, obs_ctl[k], exp_ctl(k)); end
            checks++;
            if (obs_data[k] !== m_data) begin errors++; $display("FAIL nominal k=%0d data got %h expected %h", k, obs_data[k], m_data); end
        end
    endtask

    task automatic test_running();
        logic [95:0] s, p, w;
        s = mk_ts(48'd7, 30'd500, 16'd3); p = mk_ts(48'd1, 30'd0, 16'd0); w = mk_ts(48'd0, 30'd999_999_999, 16'hffff);
        sc_drop = 3; sc_rise = 16; sc_err = -1; sc_ts = -1;
        plan(s, p, w, 1'b0);
        run_request(s, p, w, 1'b0);
        for (int k = 0; k <= m_last; k++) begin
            checks++;
            if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL running k=%0d ctl got %b expected %b", k, obs_ctl[k], exp_ctl(k)); end
            checks++;
            if (obs_data[k] !== m_data) begin errors++; $display("FAIL running k=%0d data got %h expected %h", k, obs_data[k], m_data); end
        end
    endtask

    task automatic test_bad();
        logic [95:0] s, p, w;
        s = mk_ts(48'd2, 30'd0, 16'd0); p = mk_ts(48'd0, 30'd1_000_000_000, 16'd0); w = mk_ts(48'd0, 30'd10, 16'd0);
        sc_drop = 0; sc_rise = 0; sc_err = -1; sc_ts = -1;
        plan(s, p, w, 1'b1);
        run_request(s, p, w, 1'b0);
        for (int k = 0; k <= m_last; k++) begin
            checks++;
            if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL bad_req k=%0d ctl got %b expected %b", k, obs_ctl[k], exp_ctl(k)); end
            checks++;
            if (obs_data[k] !== m_data) begin errors++; $display("FAIL bad_req k=%0d data got %h expected %h", k, obs_data[k], m_data); end
        end
    endtask

    task automatic test_timeout();
        logic [95:0] s;
        for (int rep = 0; rep < 2; rep++) begin
            s = mk_ts(48'(rep + 3), 30'd123, 16'd0);
            sc_drop = 0; sc_rise = -1; sc_err = -1; sc_ts = (rep == 0) ? -1 : 16;
            plan(s, s, s, 1'b0);
            run_request(s, s, s, 1'b0);
            for (int k = 0; k <= m_last; k++) begin
                checks++;
                if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL timeout%0d k=%0d ctl got %b expected %b", rep, k, obs_ctl[k], exp_ctl(k)); end
            end
        end
    endtask

    task automatic test_collision();
        logic [95:0] s;
        s = mk_ts(48'd9, 30'd42, 16'd0);
        sc_drop = 0; sc_rise = 12; sc_err = 12; sc_ts = -1;
        plan(s, s, s, 1'b0);
        run_request(s, s, s, 1'b0);
        for (int k = 0; k <= m_last; k++) begin
            checks++;
            if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL collision k=%0d ctl got %b expected %b", k, obs_ctl[k], exp_ctl(k)); end
        end
    endtask

    task automatic test_random();
        logic [95:0] v [3];
        logic [63:0] r64;
        logic [29:0] ns;
        int bad_sel;
        bit noise;
        for (int it = 0; it < 14; it++) begin
            bad_sel = $urandom_range(0, 11);
            for (int f = 0; f < 3; f++) begin
                r64 = {$urandom, $urandom};
                ns = (bad_sel == f) ? 30'($urandom_range(1_000_000_000, 1073741823)) : 30'($urandom_range(0, 999_999_999));
                v[f] = mk_ts(r64[47:0], ns, r64[63:48]);
            end
            noise   = $urandom_range(0, 1) == 1;
            sc_drop = $urandom_range(0, 19);
            sc_rise = ($urandom_range(0, 3) == 0) ? -1 : sc_drop + $urandom_range(1, 30);
            sc_err  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 40) : -1;
            sc_ts   = ($urandom_range(0, 2) == 0) ? $urandom_range(7, 40) : -1;
            plan(v[0], v[1], v[2], bad_sel < 3);
            run_request(v[0], v[1], v[2], noise);
            for (int k = 0; k <= m_last; k++) begin
                checks++;
                if (obs_ctl[k] !== exp_ctl(k)) begin errors++; $display("FAIL random%0d k=%0d ctl got %b expected %b", it, k, obs_ctl[k], exp_ctl(k)); end
                checks++;
                if (obs_data[k] !== m_data) begin errors++; $display("FAIL random%0d k=%0d data got %h expected %h", it, k, obs_data[k], m_data); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        cfg_start = mk_ts(48'd5, 30'd5, 16'd5); cfg_period = cfg_start; cfg_width = cfg_start;
        perout_locked = 1'b0; perout_error = 1'b0; ts_step = 1'b0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (perout_period_valid !== 1'b1) begin errors++; $display("FAIL midload_pv got %b expected 1", perout_period_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl() !== IDLE_RST) begin errors++; $display("FAIL midload_rst_ctl got %b expected %b", ctl(), IDLE_RST); end
        checks++;
        if ({perout_start, perout_period, perout_width} !== 288'd0) begin
            errors++; $display("FAIL midload_rst_data got %h expected 0", {perout_start, perout_period, perout_width});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (ctl() !== IDLE_RST) begin errors++; $display("FAIL midload_post k=%0d got %b expected %b", k, ctl(), IDLE_RST); end
        end
        m_enable = 1'b0; m_data = '0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_running();
        test_bad();
        test_timeout();
        test_collision();
        test_random();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
